mix_columns_seq: RTL and testbench

//  Forward AES MixColumns engine for the encryption datapath. It is the encrypt-side

---
 rtl/mix_columns_seq.sv | 124 ++++++++++++
 tb/tb_mix_columns_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns engine: captures one 128-bit state, mixes COLS_PER_CYCLE
// columns per cycle, and holds the result on a valid/ready output until taken.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter steps by the group width; with four columns per cycle it wraps to 0.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] cap_q, cap_d;
  logic         byp_q, byp_d;
  logic [127:0] out_state_q, out_state_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of a column sits in the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic byp);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (byp) return col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    cap_d       = cap_q;
    byp_d       = byp_q;
    out_state_d = out_state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          cap_d      = in_state;
          byp_d      = in_bypass;
          col_cnt_d  = 2'd0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < 4; c++) begin
          if (c >= int'(col_cnt_q) && c < int'(col_cnt_q) + COLS_PER_CYCLE) begin
            out_state_d[127-32*c -: 32] = mix_col(cap_q[127-32*c -: 32], byp_q);
          end
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST_COL) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      cap_q       <= '0;
      byp_q       <= 1'b0;
      out_state_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      cap_q       <= cap_d;
      byp_q       <= byp_d;
      out_state_q <= out_state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle) driven
// through directed steps, with expected states queued at capture and compared at output.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic [127:0] out_state [3];

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] sbq [$];

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_cpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_cpc2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_cpc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]));

  // Reference: generic GF(2^8) multiply against the circulant matrix [2 3 1 1].
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic byp);
    logic [127:0] r;
    logic [7:0]   a [4];
    if (byp) return st;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = st[127-8*(4*c+k) -: 8];
      for (int k = 0; k < 4; k++)
        r[127-8*(4*c+k) -: 8] = gmul(a[k], 8'd2) ^ gmul(a[(k+1)%4], 8'd3)
                                ^ a[(k+2)%4] ^ a[(k+3)%4];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input int idx);
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sbq.size() != 0) chk(tag, out_state[idx], sbq.pop_front());
  endtask

  // Called at the first falling edge after the capture edge.
  task automatic wait_out(input int idx, input int lat, input string tag);
    int n;
    n = 0;
    while (!out_valid[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
  endtask

  task automatic xact(input int idx, input logic [127:0] st, input logic byp,
                      input logic [127:0] exp, input int lat, input string tag);
    @(negedge clk);
    in_state  = st;
    in_bypass = byp;
    chk({tag, "_in_ready"}, 128'(in_ready[idx]), 128'(1));
    in_valid[idx] = 1'b1;
    sbq.push_back(exp);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    wait_out(idx, lat, tag);
    pop_chk({tag, "_data"}, idx);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    chk({tag, "_valid_drop"}, 128'(out_valid[idx]), 128'(0));
    chk({tag, "_ready_back"}, 128'(in_ready[idx]), 128'(1));
  endtask

  localparam logic [127:0] FULL_IN  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] FULL_OUT = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] BYP_IN   = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
  localparam logic [127:0] BYP_MIX  = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;

  initial begin
    logic [127:0] s2;
    int sent, recv, last;
    bit justsent;

    rst_n = 1'b0; in_valid = '0; out_ready = '0; in_state = '0; in_bypass = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 128'(in_ready[i]), 128'(1));
      chk("reset_out_valid", 128'(out_valid[i]), 128'(0));
      chk("reset_out_state", out_state[i], 128'h0);
    end
    rst_n = 1'b1;

    xact(0, 128'hdb135345_00000000_00000000_00000000, 1'b0,
         128'h8e4da1bc_00000000_00000000_00000000, 4, "fips_col");
    xact(0, FULL_IN, 1'b0, FULL_OUT, 4, "full_cpc1");
    xact(1, FULL_IN, 1'b0, FULL_OUT, 2, "full_cpc2");
    xact(2, FULL_IN, 1'b0, FULL_OUT, 1, "full_cpc4");
    xact(0, BYP_IN, 1'b1, BYP_IN, 4, "bypass_on");
    xact(0, BYP_IN, 1'b0, BYP_MIX, 4, "bypass_off");
    xact(2, BYP_IN, 1'b1, BYP_IN, 1, "bypass_cpc4");

    // Backpressure: hold the result, offer a second state meanwhile.
    @(negedge clk);
    in_state = FULL_IN; in_bypass = 1'b0; in_valid[0] = 1'b1;
    sbq.push_back(FULL_OUT);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_out(0, 4, "bp_first");
    s2 = 128'h01234567_89abcdef_fedcba98_76543210;
    in_state = s2; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_state", out_state[0], sbq[0]);
      chk("bp_hold_valid", 128'(out_valid[0]), 128'(1));
      chk("bp_hold_in_ready", 128'(in_ready[0]), 128'(0));
    end
    pop_chk("bp_first_data", 0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_release_valid", 128'(out_valid[0]), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
    sbq.push_back(model(s2, 1'b0));
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_second_captured", 128'(in_ready[0]), 128'(0));
    wait_out(0, 4, "bp_second");
    pop_chk("bp_second_data", 0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset in the middle of BUSY with two columns already written.
    @(negedge clk);
    in_state = FULL_IN; in_bypass = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midbusy_partial_state", 128'(out_state[0] != 128'h0), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(out_valid[0]), 128'(0));
    chk("abort_out_state", out_state[0], 128'h0);
    chk("abort_in_ready", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, FULL_IN, 1'b0, FULL_OUT, 4, "after_abort");

    // Back-to-back streaming with both handshakes tied high.
    sent = 0; recv = 0; last = -1; justsent = 1'b0;
    in_state  = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = ($urandom_range(0, 7) == 0);
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 6200 && recv < 1000; cyc++) begin
      if (out_valid[0]) begin
        pop_chk("b2b_data", 0);
        if (last >= 0) chk("b2b_interval", 128'(cyc - last), 128'(6));
        last = cyc;
        recv++;
      end
      if (justsent) begin
        justsent  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = ($urandom_range(0, 7) == 0);
        if (sent == 1000) in_valid[0] = 1'b0;
      end
      if (in_ready[0] && sent < 1000) begin
        sbq.push_back(model(in_state, in_bypass));
        sent++;
        justsent = 1'b1;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chk("b2b_count", 128'(recv), 128'(1000));
    chk("sb_drained", 128'(sbq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
